// File: rtl/isa_pkg.sv
// Shared MIPS encoding constants: format codes, opcodes, field positions.
// Decode splitters import the same positions so encode and decode stay aligned.
package isa_pkg;

  typedef enum logic [1:0] {
    FMT_R   = 2'd0,
    FMT_I   = 2'd1,
    FMT_J   = 2'd2,
    FMT_RAW = 2'd3
  } fmt_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL   = 6'h00;
  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;

  localparam int OP_W     = 6;
  localparam int REG_W    = 5;
  localparam int SHAMT_W  = 5;
  localparam int FUNCT_W  = 6;
  localparam int IMM_W    = 16;
  localparam int JADDR_W  = 26;

  localparam int OP_LSB    = 26;
  localparam int RS_LSB    = 21;
  localparam int RT_LSB    = 16;
  localparam int RD_LSB    = 11;
  localparam int SHAMT_LSB = 6;
  localparam int FUNCT_LSB = 0;
  localparam int IMM_LSB   = 0;
  localparam int JADDR_LSB = 0;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ACCEPT = 3'd1,
    ST_WRITE  = 3'd2,
    ST_DONE   = 3'd3,
    ST_ERROR  = 3'd4
  } asm_state_e;

endpackage

// File: rtl/instr_encoder.sv
// Combinational field packer: builds a 32-bit MIPS word from decoded fields.
module instr_encoder
  import isa_pkg::*;
(
  input  logic [1:0]  fmt_i,
  input  logic [5:0]  opcode_i,
  input  logic [4:0]  rs_i,
  input  logic [4:0]  rt_i,
  input  logic [4:0]  rd_i,
  input  logic [4:0]  shamt_i,
  input  logic [5:0]  funct_i,
  input  logic [15:0] imm_i,
  input  logic [25:0] addr_i,
  input  logic [31:0] raw_i,
  output logic [31:0] word_o
);

  always_comb begin
    word_o = '0;
    case (fmt_e'(fmt_i))
      FMT_R: begin
        word_o[OP_LSB    +: OP_W]    = opcode_i;
        word_o[RS_LSB    +: REG_W]   = rs_i;
        word_o[RT_LSB    +: REG_W]   = rt_i;
        word_o[RD_LSB    +: REG_W]   = rd_i;
        word_o[SHAMT_LSB +: SHAMT_W] = shamt_i;
        word_o[FUNCT_LSB +: FUNCT_W] = funct_i;
      end
      FMT_I: begin
        word_o[OP_LSB  +: OP_W]  = opcode_i;
        word_o[RS_LSB  +: REG_W] = rs_i;
        word_o[RT_LSB  +: REG_W] = rt_i;
        word_o[IMM_LSB +: IMM_W] = imm_i;
      end
      FMT_J: begin
        word_o[OP_LSB    +: OP_W]    = opcode_i;
        word_o[JADDR_LSB +: JADDR_W] = addr_i;
      end
      default: word_o = raw_i;
    endcase
  end

endmodule

// File: rtl/instr_assembler.sv
// Program loader: packs field tuples into MIPS words and writes them to
// instruction memory one at a time, holding the CPU until the load finishes.
module instr_assembler
  import isa_pkg::*;
#(
  parameter int          ADDR_W    = 10,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_fmt,
  input  logic [5:0]        in_opcode,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_shamt,
  input  logic [5:0]        in_funct,
  input  logic [15:0]       in_imm,
  input  logic [25:0]       in_addr,
  input  logic [31:0]       in_raw,
  input  logic              in_last,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ack,
  output logic              cpu_hold,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   count
);

  localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W:0]   CAPACITY = {1'b1, {ADDR_W{1'b0}}};

  asm_state_e        state_q, state_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [ADDR_W-1:0] addr_q,  addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              last_q,  last_d;
  logic [31:0]       packed_word;

  instr_encoder u_encoder (
    .fmt_i    (in_fmt),
    .opcode_i (in_opcode),
    .rs_i     (in_rs),
    .rt_i     (in_rt),
    .rd_i     (in_rd),
    .shamt_i  (in_shamt),
    .funct_i  (in_funct),
    .imm_i    (in_imm),
    .addr_i   (in_addr),
    .raw_i    (in_raw),
    .word_o   (packed_word)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      addr_q  <= BASE;
      wdata_q <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    last_d  = last_q;
    case (state_q)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (start) begin
          count_d = '0;
          addr_d  = BASE;
          state_d = ST_ACCEPT;
        end
      end
      ST_ACCEPT: begin
        // A full memory refuses the tuple rather than overwriting word 0.
        if (in_valid) begin
          if (count_q == CAPACITY) begin
            state_d = ST_ERROR;
          end else begin
            wdata_d = packed_word;
            last_d  = in_last;
            state_d = ST_WRITE;
          end
        end
      end
      ST_WRITE: begin
        if (mem_ack) begin
          count_d = count_q + (ADDR_W+1)'(1);
          addr_d  = addr_q + ADDR_W'(1);
          state_d = last_q ? ST_DONE : ST_ACCEPT;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs decode straight from the state register so rst clears them at once.
  assign in_ready  = (state_q == ST_ACCEPT);
  assign mem_req   = (state_q == ST_WRITE);
  assign done      = (state_q == ST_DONE);
  assign err       = (state_q == ST_ERROR);
  assign cpu_hold  = (state_q != ST_DONE);
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign count     = count_q;

endmodule

// File: doc/instr_assembler.md
Name: instr_assembler

Overview:
- Inverse of the decode-stage field extraction: accepts instruction fields (opcode, rs, rt, rd, shamt, funct, imm16, addr26) over a valid/ready stream and packs each into a 32-bit MIPS word.
- Writes the packed words sequentially into instruction memory over a req/ack write port, starting at BASE_ADDR.
- Used as the program loader ahead of fetch. Holds the CPU in reset-like stall (cpu_hold) until the program is loaded.

Parameters:
- ADDR_W, 10, word-address width of instruction memory (capacity 2^ADDR_W words).
- BASE_ADDR, 0, first word address written after each start.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset; asynchronous, active-high.
- start  in  1  one-cycle pulse; begins a load session. Honoured only in IDLE, DONE or ERROR.
- in_valid  in  1  field tuple valid.
- in_ready  out  1  block accepts tuple this cycle.
- in_fmt  in  2  0=R, 1=I, 2=J, 3=RAW.
- in_opcode  in  6  opcode field, used by R, I and J formats.
- in_rs / in_rt / in_rd  in  5 each  register IDs. I-format destination is in_rt.
- in_shamt  in  5  shift amount (R).
- in_funct  in  6  function code (R).
- in_imm  in  16  immediate (I), taken raw with no extension.
- in_addr  in  26  jump target field (J).
- in_raw  in  32  literal word (RAW).
- in_last  in  1  marks final tuple of the program.
- mem_req  out  1  write request.
- mem_addr  out  ADDR_W  word address.
- mem_wdata  out  32  packed instruction.
- mem_ack  in  1  memory accepted write (sampled while mem_req=1).
- cpu_hold  out  1  stall CPU while loading.
- done  out  1  load completed successfully (level).
- err  out  1  capacity overflow (level).
- count  out  ADDR_W+1  words written this session.

Behaviour:
- Reset values:
  - FSM=IDLE.
  - in_ready=0, mem_req=0, mem_addr=BASE_ADDR, mem_wdata=0.
  - cpu_hold=1, done=0, err=0, count=0.
- Packing:
  - R: {opcode, rs, rt, rd, shamt, funct}.
  - I: {opcode, rs, rt, imm}.
  - J: {opcode, addr}.
  - RAW: in_raw.
  - Unused fields for a format are ignored.
- FSM states:
  - IDLE: in_ready=0. On start: count←0, addr←BASE_ADDR, go to ACCEPT.
  - ACCEPT: in_ready=1.
    - On in_valid, if count==2^ADDR_W: go to ERROR, tuple not consumed.
    - On in_valid otherwise: latch packed word into mem_wdata, latch in_last, go to WRITE.
  - WRITE: mem_req=1; mem_addr and mem_wdata held stable. On mem_ack:
    - count+1 and addr+1, with addr wrapping modulo 2^ADDR_W.
    - Then go to DONE if latched last, else ACCEPT.
- Latency and handshake:
  - Tuple accepted at edge N gives mem_req=1 in cycle N+1.
  - Zero-wait ack in N+1 gives in_ready=1 again in N+2.
  - Throughput is one word per 2 cycles minimum.
  - At most one write outstanding.
  - mem_req is never dropped before ack.
- DONE: done=1, cpu_hold=0, in_ready=0.
- ERROR: err=1, cpu_hold=1, in_ready=0.
- start in DONE/ERROR clears done/err, sets cpu_hold=1, restarts the session at BASE_ADDR.
- start in ACCEPT/WRITE is ignored.
- in_valid outside ACCEPT is ignored (not consumed).
- in_valid and in_last on the very first tuple means a 1-word program; this is legal.
- Asynchronous rst mid-WRITE: mem_req drops immediately and no ack is awaited afterwards. A late ack in IDLE is ignored.
- ack in the same cycle as mem_req first rises counts as accepted.

Decomposition:
- Shared package (isa_pkg):
  - Format codes FMT_R/FMT_I/FMT_J/FMT_RAW.
  - Opcode and funct constants (OP_RTYPE=0, OP_J=2, OP_ADDI=8, OP_LW=0x23, FN_ADD=0x20, ...).
  - Field bit positions, shared with the decode splitters so encode and decode cannot diverge.
- One sub-module: instr_encoder.
  - Purely combinational field packer selected by in_fmt.
  - Reusable by testbenches for stimulus generation.
- FSM, address counter and handshake stay in instr_assembler.

Test Plan:
1. Encoding:
   - R tuple op=0, rs=1, rt=2, rd=3, shamt=0, funct=0x20 -> mem_wdata=0x00221820 at addr 0.
   - I tuple op=8, rs=0, rt=8, imm=5 -> 0x20080005.
   - J tuple op=2, addr=0x0100000 -> 0x08100000.
2. Three-tuple program (last on 3rd), ack after 2 wait cycles each:
   - addrs 0, 1, 2 written.
   - mem_req held through the waits.
   - count=3, done=1, cpu_hold=0.
3. Zero-wait ack, back-to-back valid -> in_ready pattern 1,0,1,0.
4. Overflow: ADDR_W=2, 5 tuples without last -> 4 writes, err=1 at the 5th in_valid, cpu_hold=1, 5th tuple not consumed.
5. rst asserted while mem_req=1 -> mem_req=0 asynchronously; after release all outputs are at reset values.
6. Restart: start in DONE, BASE_ADDR=0x10 -> done cleared, first write at 0x10, count restarts from 0; start pulsed during WRITE is ignored.
